// File: rtl/maze_player_ctrl.sv
// Button-driven maze player: edge/auto-repeat move requests, wall lookup handshake,
// frame-synchronous position commit, exit detection.
module maze_player_ctrl #(
    parameter int BCOL_W        = 6,
    parameter int BROW_W        = 6,
    parameter int GRID_COLS     = 40,
    parameter int GRID_ROWS     = 30,
    parameter int START_BCOL    = 1,
    parameter int START_BROW    = 1,
    parameter int EXIT_BCOL     = 37,
    parameter int EXIT_BROW     = 22,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_left,
    input  logic              i_right,
    input  logic              i_frame_start,
    output logic              o_rom_req,
    output logic [BCOL_W-1:0] o_rom_bcol,
    output logic [BROW_W-1:0] o_rom_brow,
    input  logic              i_rom_valid,
    input  logic              i_rom_wall,
    output logic [BCOL_W-1:0] o_player_bcol,
    output logic [BROW_W-1:0] o_player_brow,
    output logic [BCOL_W-1:0] o_exit_bcol,
    output logic [BROW_W-1:0] o_exit_brow,
    output logic              o_busy,
    output logic              o_win,
    output logic [15:0]       o_moves
);
    localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PEND, S_WIN} state_t;

    state_t            state_q, state_d;
    logic [3:0]        dir_q, dir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCOL_W-1:0] col_q, col_d, tcol_q, tcol_d;
    logic [BROW_W-1:0] row_q, row_d, trow_q, trow_d;
    logic [15:0]       moves_q, moves_d;

    logic [3:0] dirs;
    logic       single, move_req, blocked;

    assign dirs   = {i_right, i_left, i_down, i_up};
    assign single = (dirs != 4'd0) && ((dirs & (dirs - 4'd1)) == 4'd0);

    // A request fires on a new single direction, then every REPEAT_CYCLES while held.
    always_comb begin
        move_req = 1'b0;
        cnt_d    = cnt_q;
        dir_d    = single ? dirs : 4'd0;
        if (!single) begin
            cnt_d = '0;
        end else if (dirs != dir_q) begin
            move_req = 1'b1;
            cnt_d    = '0;
        end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            move_req = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Bounds checked one bit wider so the last column/row never wraps.
    always_comb begin
        blocked = 1'b0;
        tcol_d  = tcol_q;
        trow_d  = trow_q;
        if (state_q == S_IDLE) begin
            tcol_d = col_q;
            trow_d = row_q;
        end
        unique case (dirs)
            4'b0001: begin
                blocked = (row_q == '0);
                trow_d  = row_q - BROW_W'(1);
            end
            4'b0010: begin
                blocked = ({1'b0, row_q} + (BROW_W+1)'(1)) >= (BROW_W+1)'(GRID_ROWS);
                trow_d  = row_q + BROW_W'(1);
            end
            4'b0100: begin
                blocked = (col_q == '0);
                tcol_d  = col_q - BCOL_W'(1);
            end
            4'b1000: begin
                blocked = ({1'b0, col_q} + (BCOL_W+1)'(1)) >= (BCOL_W+1)'(GRID_COLS);
                tcol_d  = col_q + BCOL_W'(1);
            end
            default: blocked = 1'b1;
        endcase
        if (state_q != S_IDLE) begin
            tcol_d = tcol_q;
            trow_d = trow_q;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        moves_d = moves_q;
        unique case (state_q)
            S_IDLE: if (move_req && !blocked) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (i_rom_valid) state_d = i_rom_wall ? S_IDLE : S_PEND;
            S_PEND: if (i_frame_start) begin
                col_d   = tcol_q;
                row_d   = trow_q;
                moves_d = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
                state_d = (tcol_q == BCOL_W'(EXIT_BCOL) && trow_q == BROW_W'(EXIT_BROW))
                          ? S_WIN : S_IDLE;
            end
            S_WIN:  state_d = S_WIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dir_q   <= '0;
            cnt_q   <= '0;
            col_q   <= BCOL_W'(START_BCOL);
            row_q   <= BROW_W'(START_BROW);
            tcol_q  <= '0;
            trow_q  <= '0;
            moves_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tcol_q  <= tcol_d;
            trow_q  <= trow_d;
            moves_q <= moves_d;
        end
    end

    assign o_rom_req     = (state_q == S_REQ);
    assign o_rom_bcol    = o_rom_req ? tcol_q : '0;
    assign o_rom_brow    = o_rom_req ? trow_q : '0;
    assign o_player_bcol = col_q;
    assign o_player_brow = row_q;
    assign o_exit_bcol   = BCOL_W'(EXIT_BCOL);
    assign o_exit_brow   = BROW_W'(EXIT_BROW);
    assign o_busy        = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_PEND);
    assign o_win         = (state_q == S_WIN);
    assign o_moves       = moves_q;

endmodule
